// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler for the 1-to-8 demux: one grant at a time,
// HOLD cycles per grant, one dead cycle on each side of D.
module demux_rr_scheduler #(
    parameter int HOLD = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic [7:0] REQ,
    output logic [2:0] SEL,
    output logic       D,
    output logic [7:0] GNT,
    output logic       BUSY,
    output logic       DONE
);

    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACTIVE,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    last;
    logic [2:0]    pick;
    logic [2:0]    idx;
    logic          found;

    // Search starts just after the last grant, so it ends up lowest priority.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = last + 3'(i);
            if (!found && REQ[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            SEL   <= '0;
            D     <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            cnt   <= '0;
            last  <= 3'd7;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (EN && found) begin
                        state <= SETUP;
                        SEL   <= pick;
                        last  <= pick;
                        BUSY  <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= ACTIVE;
                    D     <= 1'b1;
                    cnt   <= CW'(HOLD - 1);
                end
                ACTIVE: begin
                    if (cnt == '0) begin
                        state <= GAP;
                        D     <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign GNT = D ? (8'b1 << SEL) : 8'd0;

endmodule
